pkt_emptylist_ctrl: RTL and testbench

Owns the pool of free packet IDs (one ID = one 2 KB, 32-flit slot in the packet buffer) and serves them to the ingress writer.
- After reset, it fills its free FIFO with every ID in order.
- It then hands out IDs through a show-ahead valid/ready port, consumed on SOP.
- It accepts released IDs from the egress/drop path.
- It tracks per-ID allocation state, rejects illegal frees and exposes occupancy/error status.

---
 rtl/pkt_emptylist_ctrl.sv | 123 ++++++++++++
 tb/tb_pkt_emptylist_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pkt_emptylist_ctrl.sv
// Free packet-ID pool: fills a circular ID FIFO after reset, serves IDs show-ahead,
// takes released IDs back and rejects frees of IDs that are not currently allocated.
module pkt_emptylist_ctrl #(
  parameter int PKT_AWIDTH = 9,
  parameter int NUM_PKTS   = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [PKT_AWIDTH-1:0] emptylist_out_data,
  output logic                  emptylist_out_valid,
  input  logic                  emptylist_out_ready,
  input  logic [PKT_AWIDTH-1:0] free_data,
  input  logic                  free_valid,
  output logic                  free_ready,
  output logic                  init_done,
  output logic [PKT_AWIDTH:0]   free_count,
  output logic                  err_underflow,
  output logic                  err_bad_free
);

  localparam int IDX_W = $clog2(NUM_PKTS);
  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NUM_PKTS - 1);
  localparam logic [PKT_AWIDTH:0] NUM_PKTS_C = (PKT_AWIDTH + 1)'(NUM_PKTS);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t state_q, state_d;

  logic [PKT_AWIDTH-1:0] fifo_mem [NUM_PKTS];
  logic [IDX_W-1:0]      rd_ptr, wr_ptr, init_cnt;
  logic [NUM_PKTS-1:0]   alloc;

  logic                  pop, underflow, free_legal, free_bad;
  logic                  fifo_we;
  logic [PKT_AWIDTH-1:0] fifo_wdata;
  logic                  in_range;
  logic [IDX_W-1:0]      free_idx, head_idx;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign emptylist_out_data = fifo_mem[rd_ptr];
  assign in_range           = ({1'b0, free_data} < NUM_PKTS_C);
  assign free_idx           = free_data[IDX_W-1:0];
  assign head_idx           = emptylist_out_data[IDX_W-1:0];

  always_comb begin
    state_d             = state_q;
    emptylist_out_valid = 1'b0;
    free_ready          = 1'b0;
    pop                 = 1'b0;
    underflow           = 1'b0;
    free_legal          = 1'b0;
    free_bad            = 1'b0;
    fifo_we             = 1'b0;
    fifo_wdata          = '0;
    case (state_q)
      ST_INIT: begin
        fifo_we    = 1'b1;
        fifo_wdata = PKT_AWIDTH'(init_cnt);
        if (init_cnt == LAST_IDX) state_d = ST_RUN;
      end
      ST_RUN: begin
        emptylist_out_valid = (free_count != '0);
        free_ready          = 1'b1;
        pop                 = emptylist_out_ready && (free_count != '0);
        underflow           = emptylist_out_ready && (free_count == '0);
        // An ID popped this cycle still has its alloc bit clear, so freeing it is rejected.
        if (free_valid) begin
          if (in_range && alloc[free_idx]) begin
            free_legal = 1'b1;
            fifo_we    = 1'b1;
            fifo_wdata = free_data;
          end else begin
            free_bad = 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_INIT;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      init_cnt      <= '0;
      free_count    <= '0;
      alloc         <= '0;
      init_done     <= 1'b0;
      err_underflow <= 1'b0;
      err_bad_free  <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_done     <= (state_d == ST_RUN);
      err_underflow <= underflow;
      err_bad_free  <= free_bad;
      if (state_q == ST_INIT) init_cnt <= init_cnt + 1'b1;
      if (fifo_we) wr_ptr <= wrap_inc(wr_ptr);
      if (pop) begin
        rd_ptr          <= wrap_inc(rd_ptr);
        alloc[head_idx] <= 1'b1;
      end
      if (free_legal) alloc[free_idx] <= 1'b0;
      case ({fifo_we, pop})
        2'b10:   free_count <= free_count + 1'b1;
        2'b01:   free_count <= free_count - 1'b1;
        default: free_count <= free_count;
      endcase
    end
  end

  // Storage is not reset; the INIT sweep rewrites every entry before it is read.
  always_ff @(posedge clk) begin
    if (!rst && fifo_we) fifo_mem[wr_ptr] <= fifo_wdata;
  end

endmodule

// File: tb/tb_pkt_emptylist_ctrl.sv
// Bench for pkt_emptylist_ctrl: directed scenarios plus a random phase, all checked
// against a queue-based model of the free pool and allocation set.
module tb_pkt_emptylist_ctrl;

  localparam int AW = 4;
  localparam int NP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] emptylist_out_data;
  logic          emptylist_out_valid;
  logic          emptylist_out_ready = 1'b0;
  logic [AW-1:0] free_data = '0;
  logic          free_valid = 1'b0;
  logic          free_ready;
  logic          init_done;
  logic [AW:0]   free_count;
  logic          err_underflow;
  logic          err_bad_free;

  int checks   = 0;
  int failures = 0;

  int fifo_m[$];
  bit alloc_m[NP];
  bit run_m;
  int init_m;
  bit exp_uf, exp_bad;

  pkt_emptylist_ctrl #(.PKT_AWIDTH(AW), .NUM_PKTS(NP)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .emptylist_out_data  (emptylist_out_data),
    .emptylist_out_valid (emptylist_out_valid),
    .emptylist_out_ready (emptylist_out_ready),
    .free_data           (free_data),
    .free_valid          (free_valid),
    .free_ready          (free_ready),
    .init_done           (init_done),
    .free_count          (free_count),
    .err_underflow       (err_underflow),
    .err_bad_free        (err_bad_free)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    emptylist_out_ready = 1'b0;
    free_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_valid", 32'(emptylist_out_valid), 0);
      chk("rst_free_ready", 32'(free_ready), 0);
      chk("rst_init_done", 32'(init_done), 0);
      chk("rst_count", 32'(free_count), 0);
      chk("rst_err_uf", 32'(err_underflow), 0);
      chk("rst_err_bad", 32'(err_bad_free), 0);
    end
    rst = 1'b0;
    fifo_m.delete();
    foreach (alloc_m[i]) alloc_m[i] = 1'b0;
    run_m   = 1'b0;
    init_m  = 0;
    exp_uf  = 1'b0;
    exp_bad = 1'b0;
  endtask

  // One clock: drive inputs, check the outputs the model predicts, then advance the model.
  task automatic cycle(input bit r, input bit fv, input int fd);
    bit exp_valid, pop, legal;
    int id;
    emptylist_out_ready = r;
    free_valid = fv;
    free_data  = AW'(fd);
    @(negedge clk);
    exp_valid = run_m && (fifo_m.size() != 0);
    chk("valid", 32'(emptylist_out_valid), 32'(exp_valid));
    if (exp_valid) chk("data", 32'(emptylist_out_data), 32'(fifo_m[0]));
    chk("free_ready", 32'(free_ready), 32'(run_m));
    chk("init_done", 32'(init_done), 32'(run_m));
    chk("free_count", 32'(free_count), 32'(fifo_m.size()));
    chk("err_underflow", 32'(err_underflow), 32'(exp_uf));
    chk("err_bad_free", 32'(err_bad_free), 32'(exp_bad));
    if (!run_m) begin
      fifo_m.push_back(init_m);
      init_m++;
      if (init_m == NP) run_m = 1'b1;
      exp_uf  = 1'b0;
      exp_bad = 1'b0;
    end else begin
      pop     = r && exp_valid;
      legal   = fv && (fd < NP) && alloc_m[fd];
      exp_uf  = r && !exp_valid;
      exp_bad = fv && !legal;
      if (pop) begin
        id = fifo_m.pop_front();
        alloc_m[id] = 1'b1;
      end
      if (legal) begin
        fifo_m.push_back(fd);
        alloc_m[fd] = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic int pick_free_id();
    int start, pick;
    pick = -1;
    if ($urandom_range(0, 9) < 7) begin
      start = $urandom_range(0, NP - 1);
      for (int k = 0; k < NP; k++)
        if (pick < 0 && alloc_m[(start + k) % NP]) pick = (start + k) % NP;
    end
    if (pick < 0) pick = $urandom_range(0, 15);
    return pick;
  endfunction

  initial begin
    // Init sweep with ready and free noise that must be ignored, then drain and underflow.
    do_reset();
    repeat (NP) cycle(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 15));
    repeat (NP + 1) cycle(1'b1, 1'b0, 0);
    repeat (2) cycle(1'b0, 1'b0, 0);

    // Release order is preserved behind the remaining init-order IDs.
    do_reset();
    repeat (NP) cycle(1'b0, 1'b0, 0);
    repeat (3) cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b1, 1);
    cycle(1'b0, 1'b1, 2);
    repeat (NP) cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b0, 0);

    // Illegal frees: unallocated, out of range, double free.
    do_reset();
    repeat (NP) cycle(1'b0, 1'b0, 0);
    repeat (2) cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b1, 5);
    cycle(1'b0, 1'b1, 9);
    cycle(1'b0, 1'b1, 0);
    cycle(1'b0, 1'b1, 0);
    repeat (NP) cycle(1'b1, 1'b0, 0);

    // Empty pool refill, pop with simultaneous free, and freeing the ID being popped.
    cycle(1'b0, 1'b1, 4);
    cycle(1'b1, 1'b1, 6);
    cycle(1'b0, 1'b0, 0);
    cycle(1'b1, 1'b1, 6);
    repeat (2) cycle(1'b0, 1'b0, 0);

    // Reset mid-INIT and mid-RUN restarts the pool from scratch.
    do_reset();
    repeat (4) cycle(1'b0, 1'b0, 0);
    do_reset();
    repeat (NP) cycle(1'b0, 1'b0, 0);
    repeat (3) cycle(1'b1, 1'b0, 0);
    do_reset();
    repeat (NP) cycle(1'b0, 1'b0, 0);
    cycle(1'b0, 1'b1, 0);
    cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b0, 0);

    // Random traffic.
    repeat (400) cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4), pick_free_id());
    cycle(1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
